// File: rtl/arb_sched_rr_if.sv
// Requester/resource signal bundle for arb_sched_rr.
// The arbiter uses the slave modport; the requester/resource side uses master.
interface arb_sched_rr_if #(
  parameter int N    = 4,
  parameter int LOGN = 2
);
  logic [N-1:0]    req_i;
  logic [N-1:0]    grant_o;
  logic [LOGN-1:0] owner_o;
  logic [N-1:0]    ack_i;
  logic            req_o;
  logic            ack_o;
  logic            busy_o;
  logic            timeout_o;

  modport slave (
    input  req_i, ack_o,
    output grant_o, owner_o, ack_i, req_o, busy_o, timeout_o
  );

  modport master (
    output req_i, ack_o,
    input  grant_o, owner_o, ack_i, req_o, busy_o, timeout_o
  );
endinterface

// File: rtl/arb_sched_rr.sv
// N-way round-robin arbiter that runs the req_o/ack_o handshake for the winner.
// Define ARB_RANDOM_PRIO_EN to start the scan from an 8-bit LFSR instead of ptr.
module arb_sched_rr #(
  parameter int N        = 4,
  parameter int LOGN     = 2,
  parameter int HOLD_MAX = 8
) (
  input  logic         clk,
  input  logic         rstn,
  arb_sched_rr_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  localparam logic [7:0]   HOLD_LAST = 8'(HOLD_MAX - 1);
  localparam logic [N-1:0] ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [LOGN-1:0] owner_q, owner_d;
  logic [N-1:0]    ack_q, ack_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;
  logic [LOGN-1:0] ptr_q, ptr_d;
  logic [7:0]      cnt_q, cnt_d;

  logic [LOGN-1:0] scan_start;
  logic [LOGN-1:0] scan_idx;
  logic [LOGN-1:0] win_idx;
  logic            win_found;
  logic [LOGN-1:0] next_ptr;

`ifdef ARB_RANDOM_PRIO_EN
  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr_q <= 8'h01;
    else       lfsr_q <= lfsr_d;
  end

  always_comb begin
    scan_start = LOGN'(int'(lfsr_q) % N);
  end
`else
  always_comb begin
    scan_start = ptr_q;
  end
`endif

  // Circular priority scan: first set request at or after scan_start.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = LOGN'((int'(scan_start) + i) % N);
      if (!win_found && bus.req_i[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    next_ptr = (int'(owner_q) == N - 1) ? '0 : owner_q + LOGN'(1);
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ack_d     = '0;
    req_d     = req_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_REQ;
          grant_d = ONE_HOT0 << win_idx;
          owner_d = win_idx;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_REQ: begin
        // An accept on the same edge as a withdrawn request still wins.
        if (bus.ack_o) begin
          state_d = ST_BUSY;
          req_d   = 1'b0;
          ack_d   = grant_q;
          cnt_d   = '0;
        end else if (!bus.req_i[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          req_d   = 1'b0;
          busy_d  = 1'b0;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (!bus.req_i[owner_q] || cnt_q == HOLD_LAST) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          ptr_d     = next_ptr;
          timeout_d = bus.req_i[owner_q];
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ack_q     <= '0;
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ack_q     <= ack_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.owner_o   = owner_q;
  assign bus.ack_i     = ack_q;
  assign bus.req_o     = req_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_arb_sched_rr.sv
// Self-checking bench for arb_sched_rr: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_arb_sched_rr;

  localparam int NREQ = 4;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   model_ptr = 0;

  arb_sched_rr_if #(.N(NREQ), .LOGN(2)) bus ();

  arb_sched_rr #(.N(NREQ), .LOGN(2), .HOLD_MAX(HOLD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // First set bit of r scanning circularly upward from start.
  function automatic int model_winner(input logic [3:0] r, input int start);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(start + i) % NREQ]) return (start + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [3:0] bit_of(input int g);
    logic [3:0] v;
    v = 4'd0;
    v[g] = 1'b1;
    return v;
  endfunction

  task automatic do_reset();
    bus.req_i = '0;
    bus.ack_o = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    model_ptr = 0;
  endtask

  task automatic test_reset();
    bus.req_i = '0;
    bus.ack_o = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_grant got=%b exp=0000", bus.grant_o); end
    n_cmp++; if (bus.owner_o !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_owner got=%0d exp=0", bus.owner_o); end
    n_cmp++; if (bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_ack_i got=%b exp=0000", bus.ack_i); end
    n_cmp++; if (bus.req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req_o got=%b exp=0", bus.req_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", bus.busy_o); end
    n_cmp++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_timeout got=%b exp=0", bus.timeout_o); end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0) begin n_fail++; $display("[TB] FAIL idle_no_req got=%b exp=0000", bus.grant_o); end
    model_ptr = 0;
  endtask

  task automatic test_basic();
    do_reset();
    bus.req_i = 4'b1010;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL basic_grant got=%b exp=0010", bus.grant_o); end
    n_cmp++; if (bus.owner_o !== 2'd1) begin n_fail++; $display("[TB] FAIL basic_owner got=%0d exp=1", bus.owner_o); end
    n_cmp++; if (bus.req_o !== 1'b1 || bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_req_busy got=%b%b exp=11", bus.req_o, bus.busy_o); end
    bus.ack_o = 1'b1;
    @(negedge clk);
    bus.ack_o = 1'b0;
    n_cmp++; if (bus.ack_i !== 4'b0010) begin n_fail++; $display("[TB] FAIL basic_ack_i got=%b exp=0010", bus.ack_i); end
    n_cmp++; if (bus.req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_req_drop got=%b exp=0", bus.req_o); end
    @(negedge clk);
    n_cmp++; if (bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL basic_ack_pulse got=%b exp=0000", bus.ack_i); end
    bus.req_i = 4'b1001;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_release got=%b/%b exp=0000/0", bus.grant_o, bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b1000) begin n_fail++; $display("[TB] FAIL basic_next_grant got=%b exp=1000", bus.grant_o); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    bus.req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      g = model_winner(4'b1111, model_ptr);
      n_cmp++; if (bus.grant_o !== bit_of(g)) begin n_fail++; $display("[TB] FAIL rr_grant[%0d] got=%b exp=%b", k, bus.grant_o, bit_of(g)); end
      bus.ack_o = 1'b1;
      @(negedge clk);
      bus.ack_o = 1'b0;
      n_cmp++; if (bus.ack_i !== bit_of(g)) begin n_fail++; $display("[TB] FAIL rr_ack[%0d] got=%b exp=%b", k, bus.ack_i, bit_of(g)); end
      repeat (2) @(negedge clk);
      bus.req_i[g] = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.grant_o !== 4'b0) begin n_fail++; $display("[TB] FAIL rr_release[%0d] got=%b exp=0000", k, bus.grant_o); end
      model_ptr = (g + 1) % NREQ;
      bus.req_i[g] = 1'b1;
    end
    bus.req_i = '0;
  endtask

  task automatic test_timeout();
    int seen;
    do_reset();
    bus.req_i = 4'b0100;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL to_grant got=%b exp=0100", bus.grant_o); end
    bus.ack_o = 1'b1;
    @(negedge clk);
    bus.ack_o = 1'b0;
    n_cmp++; if (bus.ack_i !== 4'b0100) begin n_fail++; $display("[TB] FAIL to_ack got=%b exp=0100", bus.ack_i); end
    seen = 0;
    for (int c = 1; c <= 12 && seen == 0; c++) begin
      @(negedge clk);
      if (bus.timeout_o === 1'b1) seen = c;
    end
    n_cmp++; if (seen != HOLD) begin n_fail++; $display("[TB] FAIL to_latency got=%0d exp=%0d", seen, HOLD); end
    n_cmp++; if (bus.grant_o !== 4'b0 || bus.busy_o !== 1'b0) begin n_fail++; $display("[TB] FAIL to_grant_cleared got=%b/%b exp=0000/0", bus.grant_o, bus.busy_o); end
    @(negedge clk);
    n_cmp++; if (bus.timeout_o !== 1'b0) begin n_fail++; $display("[TB] FAIL to_pulse_width got=%b exp=0", bus.timeout_o); end
    n_cmp++; if (bus.grant_o !== 4'b0100) begin n_fail++; $display("[TB] FAIL to_regrant got=%b exp=0100", bus.grant_o); end
    bus.req_i = '0;
  endtask

  task automatic test_abort();
    do_reset();
    bus.req_i = 4'b1000;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b1000) begin n_fail++; $display("[TB] FAIL abort_grant got=%b exp=1000", bus.grant_o); end
    bus.req_i = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0 || bus.busy_o !== 1'b0 || bus.req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_idle got=%b/%b/%b exp=0000/0/0", bus.grant_o, bus.busy_o, bus.req_o); end
    n_cmp++; if (bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL abort_no_ack got=%b exp=0000", bus.ack_i); end
    bus.req_i = 4'b0010;
    @(negedge clk);
    bus.req_i = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.ack_i !== 4'b0 || bus.grant_o !== 4'b0) begin n_fail++; $display("[TB] FAIL abort2_idle got=%b/%b exp=0000/0000", bus.ack_i, bus.grant_o); end
    bus.req_i = 4'b0110;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0010) begin n_fail++; $display("[TB] FAIL abort_ptr_kept got=%b exp=0010", bus.grant_o); end
    bus.req_i = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req_i = 4'b0001;
    @(negedge clk);
    bus.ack_o = 1'b1;
    @(negedge clk);
    bus.ack_o = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("[TB] FAIL ar_busy got=%b exp=1", bus.busy_o); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (bus.grant_o !== 4'b0 || bus.busy_o !== 1'b0 || bus.req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL ar_clear got=%b/%b/%b exp=0000/0/0", bus.grant_o, bus.busy_o, bus.req_o); end
    n_cmp++; if (bus.ack_i !== 4'b0 || bus.timeout_o !== 1'b0 || bus.owner_o !== 2'd0) begin n_fail++; $display("[TB] FAIL ar_pulses got=%b/%b/%0d exp=0000/0/0", bus.ack_i, bus.timeout_o, bus.owner_o); end
    @(negedge clk);
    rstn = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    n_cmp++; if (bus.grant_o !== 4'b0001) begin n_fail++; $display("[TB] FAIL ar_regrant got=%b exp=0001", bus.grant_o); end
    bus.req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [3:0] r;
    int g, d, j, end_k, k;
    bit to_exp;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      r = 4'($urandom_range(1, 15));
      bus.req_i = r;
      @(negedge clk);
      g = model_winner(r, model_ptr);
      n_cmp++; if (bus.grant_o !== bit_of(g) || bus.owner_o !== 2'(g)) begin n_fail++; $display("[TB] FAIL rnd_grant[%0d] got=%b/%0d exp=%b/%0d", t, bus.grant_o, bus.owner_o, bit_of(g), g); end
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        n_cmp++; if (bus.grant_o !== bit_of(g) || bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL rnd_req_hold[%0d] got=%b/%b exp=%b/0000", t, bus.grant_o, bus.ack_i, bit_of(g)); end
      end
      if ($urandom_range(0, 3) == 0) begin
        bus.req_i = r & ~bit_of(g);
        @(negedge clk);
        bus.req_i = '0;
        n_cmp++; if (bus.grant_o !== 4'b0 || bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL rnd_abort[%0d] got=%b/%b exp=0000/0000", t, bus.grant_o, bus.ack_i); end
      end else begin
        bus.ack_o = 1'b1;
        @(negedge clk);
        bus.ack_o = 1'b0;
        n_cmp++; if (bus.ack_i !== bit_of(g) || bus.req_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_ack[%0d] got=%b/%b exp=%b/0", t, bus.ack_i, bus.req_o, bit_of(g)); end
        j = $urandom_range(0, 11);
        end_k = (j + 1 < HOLD) ? j + 1 : HOLD;
        to_exp = (j + 1 > HOLD);
        k = 0;
        while (k < end_k) begin
          if (k == j) bus.req_i = r & ~bit_of(g);
          @(negedge clk);
          k++;
          n_cmp++; if (bus.grant_o !== ((k < end_k) ? bit_of(g) : 4'b0) || bus.ack_i !== 4'b0) begin n_fail++; $display("[TB] FAIL rnd_busy[%0d.%0d] got=%b/%b j=%0d", t, k, bus.grant_o, bus.ack_i, j); end
          n_cmp++; if (bus.timeout_o !== (k == end_k && to_exp)) begin n_fail++; $display("[TB] FAIL rnd_timeout[%0d.%0d] got=%b exp=%b", t, k, bus.timeout_o, (k == end_k && to_exp)); end
        end
        bus.req_i = '0;
        model_ptr = (g + 1) % NREQ;
      end
      @(negedge clk);
      n_cmp++; if (bus.grant_o !== 4'b0 || bus.timeout_o !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_idle[%0d] got=%b/%b exp=0000/0", t, bus.grant_o, bus.timeout_o); end
    end
  endtask

  task automatic test_random_prio();
    logic [3:0] seen;
    seen = 4'b0;
    do_reset();
    for (int t = 0; t < 64; t++) begin
      bus.req_i = 4'b1111;
      @(negedge clk);
      n_cmp++; if ($onehot(bus.grant_o) !== 1'b1) begin n_fail++; $display("[TB] FAIL rp_onehot[%0d] got=%b exp=one-hot", t, bus.grant_o); end
      seen = seen | bus.grant_o;
      bus.ack_o = 1'b1;
      @(negedge clk);
      bus.ack_o = 1'b0;
      bus.req_i = '0;
      @(negedge clk);
      n_cmp++; if (bus.grant_o !== 4'b0) begin n_fail++; $display("[TB] FAIL rp_release[%0d] got=%b exp=0000", t, bus.grant_o); end
    end
    n_cmp++; if (seen !== 4'b1111) begin n_fail++; $display("[TB] FAIL rp_coverage got=%b exp=1111", seen); end
  endtask

  initial begin
    bus.req_i = '0;
    bus.ack_o = 1'b0;
    test_reset();
`ifdef ARB_RANDOM_PRIO_EN
    test_timeout();
    test_async_reset();
    test_random_prio();
`else
    test_basic();
    test_round_robin();
    test_timeout();
    test_abort();
    test_async_reset();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/arb_sched_rr.md
# arb_sched_rr

Sequential N-way arbiter and scheduler sitting between N requesters and one shared resource port. It picks one requester per transaction and runs the `req_o`/`ack_o` handshake with the resource on the winner's behalf. It holds the grant until the winner releases it or a hold timeout expires, then rotates priority. It replaces purely combinational priority chains wherever fairness and grant persistence are required.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `LOGN`, default 2: index width, must equal ceil(log2(N)).
- `HOLD_MAX`, default 8: maximum BUSY cycles per grant, 1..255.
- `clk`  in  1: single clock, rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `req_i`  in  N: request per requester; level, held until served.
- `grant_o`  out  N: one-hot current owner; all-zero when no owner.
- `owner_o`  out  LOGN: binary index of owner; valid only while `grant_o != 0`.
- `ack_i`  out  N: one-cycle pulse to the owner when the resource accepts.
- `req_o`  out  1: request to the shared resource.
- `ack_o`  in  1: resource accept; sampled only in REQ.
- `busy_o`  out  1: high in REQ and BUSY.
- `timeout_o`  out  1: one-cycle pulse on forced release.

## Operation
- FSM states: IDLE, REQ, BUSY. Reset puts the FSM in IDLE.
- Reset values: `grant_o=0`, `owner_o=0`, `ack_i=0`, `req_o=0`, `busy_o=0`, `timeout_o=0`, pointer `ptr=0`, hold counter `cnt=0`.
- IDLE:
  - If `req_i != 0`, winner g is the first set bit of `req_i` scanning circularly from `ptr` upward (ptr, ptr+1, …, N-1, 0, …).
  - Latch g, set `grant_o = 1<<g`, `req_o=1`, go to REQ.
  - If `req_i == 0`, stay in IDLE.
- REQ:
  - `ack_o=1`: go to BUSY, drop `req_o`, pulse `ack_i[g]`, set `cnt=0`.
  - `req_i[g]=0` with `ack_o=0`: abort to IDLE, clear grant, `ptr` unchanged.
  - `ack_o=1` together with `req_i[g]=0`: the accept wins; go to BUSY, then release on the next cycle.
- BUSY:
  - `cnt` increments every cycle.
  - `req_i[g]=0`: go to IDLE, clear grant, `ptr = (g+1) mod N`.
  - Else if `cnt == HOLD_MAX-1`: forced release to IDLE, pulse `timeout_o`, `ptr = (g+1) mod N`.
  - Requester release has priority over timeout on the same cycle; `timeout_o` stays 0.
- Changes to `req_i` bits other than g are ignored outside IDLE.
- `grant_o` is always one-hot or zero. `ack_i` is only ever set on the bit that is set in `grant_o`.
- Reset asserted mid-transaction clears all state asynchronously; no `ack_i` or `timeout_o` pulse is emitted.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Arbitration: `req_i` is sampled at IDLE edge k; `grant_o`, `owner_o`, `req_o` and `busy_o` are valid from k+1.
- Accept: `ack_o` high at edge m in REQ; `ack_i[g]` is high for cycle m+1 only and `req_o` is low from m+1.
- Release: `req_i[g]` low at edge r in BUSY; `grant_o=0` and `busy_o=0` from r+1.
- Timeout: `timeout_o` is high for exactly one cycle, coincident with the first cycle of `grant_o=0`.
- Back-to-back throughput: at least one IDLE cycle between consecutive grants; minimum 3 cycles per transaction (IDLE, REQ, BUSY).

## Configuration
- `ARB_RANDOM_PRIO_EN`:
  - Defined: the scan start is `lfsr mod N` instead of `ptr`, where `lfsr` is an internal 8-bit Fibonacci LFSR.
  - LFSR feedback: `q[0] <= q[7]^q[5]^q[4]^q[3]`, shift left.
  - LFSR reset value 8'h01; advances every cycle in all states.
  - `ptr` is still maintained but unused.
- Not defined: the LFSR is absent and strict round-robin via `ptr` applies.

## Test plan
- Reset then `req_i=4'b1010`, `ack_o=1` one cycle after `req_o` rises:
  - `grant_o=4'b0010`, `owner_o=1`.
  - `ack_i=4'b0010` for one cycle.
  - Drop `req_i[1]`: `ptr=2`, next grant `4'b1000`.
- All `req_i=4'b1111` held, each owner drops its request 2 cycles after `ack_i`: grant sequence 0,1,2,3,0.
- `req_i=4'b0100` held, `HOLD_MAX=8`, `ack_o` immediate:
  - `timeout_o` pulses 8 cycles after `ack_i`.
  - `grant_o=0` on that cycle.
  - Next grant is bit 2 again, after one IDLE cycle.
- In REQ with owner 3, drop `req_i[3]` while `ack_o=0`: FSM to IDLE, `ack_i` never pulses, `ptr` unchanged (0).
- `rstn` asserted low in BUSY: all outputs 0 immediately without a clock edge; after release, `req_i=4'b0001` is granted to bit 0.
- With `ARB_RANDOM_PRIO_EN`, `req_i=4'b1111` for 64 transactions: every index is granted at least once and `grant_o` is always one-hot.
